// File: rtl/mix_pdm.sv
// mix_pdm: snapshots CHANNELS voices on a strobe and mixes them one channel
// per cycle with per-channel gain shift and mute. The sum is saturated to WIDTH
// bits and held, and a 1st/2nd-order delta-sigma modulator turns the held mix
// into a 1-bit PDM stream.
module mix_pdm #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12,
  parameter int ORDER    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic [CHANNELS*2-1:0]     gain,
  input  logic [CHANNELS-1:0]       mute,
  input  logic                      update,
  output logic                      busy,
  output logic [WIDTH-1:0]          mix_out,
  output logic                      mix_valid,
  output logic                      clip,
  output logic                      pdm
);
  // Three guard bits keep the sum of up to 8 full-scale terms overflow-free.
  localparam int ACC_W = WIDTH + 3;
  localparam int IDX_W = $clog2(CHANNELS + 1);

  localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIX_MIN = ACC_W'(-(2 ** (WIDTH - 1)));

  function automatic logic mix_clips(input logic signed [ACC_W-1:0] v);
    return (v > MIX_MAX) || (v < MIX_MIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_mix(input logic signed [ACC_W-1:0] v);
    if (v > MIX_MAX) return MIX_MAX[WIDTH-1:0];
    if (v < MIX_MIN) return MIX_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      busy_q, busy_d;
  logic                      vld_q, vld_d;
  logic                      clip_q, clip_d;
  logic signed [WIDTH-1:0]   mix_q, mix_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CHANNELS*WIDTH-1:0] snap_q;
  logic [CHANNELS*2-1:0]     gain_snap_q;
  logic [CHANNELS-1:0]       mute_snap_q;
  logic                      load;

  logic signed [WIDTH-1:0]   samp_sel;
  logic signed [WIDTH-1:0]   samp_shift;
  logic [1:0]                gain_sel;
  logic                      mute_sel;
  logic signed [ACC_W-1:0]   term;
  logic [WIDTH-1:0]          u;
  logic                      pdm_q;

  // Select the current channel's snapshot and form its gained, muted term.
  always_comb begin
    samp_sel = '0;
    gain_sel = '0;
    mute_sel = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        samp_sel = snap_q[k*WIDTH +: WIDTH];
        gain_sel = gain_snap_q[2*k +: 2];
        mute_sel = mute_snap_q[k];
      end
    end
    samp_shift = samp_sel >>> gain_sel;
    term       = mute_sel ? '0 : {{3{samp_shift[WIDTH-1]}}, samp_shift};
  end

  // Mix sequencer: accumulate one channel per cycle, then saturate and publish.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    mix_d   = mix_q;
    clip_d  = clip_q;
    vld_d   = 1'b0;
    acc_d   = acc_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (update) begin
          load    = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
          busy_d  = 1'b1;
        end
      end
      ACCUM: begin
        if (idx_q == IDX_W'(CHANNELS)) begin
          mix_d   = sat_mix(acc_q);
          clip_d  = mix_clips(acc_q);
          vld_d   = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
          // A strobe on the publishing cycle starts the next pass right away.
          if (update) begin
            load    = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ACCUM;
            busy_d  = 1'b1;
          end
        end else begin
          acc_d = acc_q + term;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and published results; reset aborts any pass in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      clip_q  <= 1'b0;
      mix_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      clip_q  <= clip_d;
      mix_q   <= mix_d;
    end
  end

  // Datapath registers: snapshot and accumulator are always loaded before use.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (load) begin
      snap_q      <= sample_in;
      gain_snap_q <= gain;
      mute_snap_q <= mute;
    end
  end

  // Offset-binary level for the modulator: 0 .. 2^WIDTH-1.
  assign u = {~mix_q[WIDTH-1], mix_q[WIDTH-2:0]};

  if (ORDER == 2) begin : g_order2
    localparam int MOD_W = WIDTH + 5;
    localparam logic signed [MOD_W-1:0] I1_MAX = MOD_W'((2 ** (WIDTH + 1)) - 1);
    localparam logic signed [MOD_W-1:0] I1_MIN = MOD_W'(-(2 ** (WIDTH + 1)));
    localparam logic signed [MOD_W-1:0] I2_MAX = MOD_W'((2 ** (WIDTH + 3)) - 1);
    localparam logic signed [MOD_W-1:0] I2_MIN = MOD_W'(-(2 ** (WIDTH + 3)));

    function automatic logic signed [MOD_W-1:0] clamp(input logic signed [MOD_W-1:0] v,
                                                      input logic signed [MOD_W-1:0] lo,
                                                      input logic signed [MOD_W-1:0] hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
    endfunction

    logic signed [WIDTH+1:0] i1_q;
    logic signed [WIDTH+3:0] i2_q;
    logic signed [MOD_W-1:0] u_ext, fb, i1_sum, i2_sum, i1_d, i2_d;

    // Two cascaded integrators with 0/2^WIDTH feedback; both clamp instead of wrapping.
    always_comb begin
      u_ext  = MOD_W'(u);
      fb     = pdm_q ? MOD_W'(2 ** WIDTH) : '0;
      i1_sum = MOD_W'(i1_q) + u_ext - fb;
      i2_sum = MOD_W'(i2_q) + MOD_W'(i1_q) + u_ext - (fb <<< 1);
      i1_d   = clamp(i1_sum, I1_MIN, I1_MAX);
      i2_d   = clamp(i2_sum, I2_MIN, I2_MAX);
    end

    // Integrator state and output bit: pdm is 1 when the new i2 is non-negative.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        i1_q  <= '0;
        i2_q  <= '0;
        pdm_q <= 1'b0;
      end else begin
        i1_q  <= i1_d[WIDTH+1:0];
        i2_q  <= i2_d[WIDTH+3:0];
        pdm_q <= ~i2_d[MOD_W-1];
      end
    end
  end else begin : g_order1
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   sum;

    // Phase accumulator; the carry out is the PDM bit.
    always_comb sum = {1'b0, a_q} + {1'b0, u};

    // Accumulator state and registered carry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q   <= '0;
        pdm_q <= 1'b0;
      end else begin
        a_q   <= sum[WIDTH-1:0];
        pdm_q <= sum[WIDTH];
      end
    end
  end

  assign busy      = busy_q;
  assign mix_out   = mix_q;
  assign mix_valid = vld_q;
  assign clip      = clip_q;
  assign pdm       = pdm_q;
endmodule

// File: doc/mix_pdm.md
# mix_pdm

Parametrised multi-voice audio back end: snapshots CHANNELS signed voice samples on a strobe and mixes them serially, one channel per cycle, with per-channel gain shift and mute. It saturates the sum to WIDTH bits and holds the result. A free-running delta-sigma modulator of selectable order (1 or 2) turns the held result into a 1-bit PDM stream. It replaces the single-resonator/first-order path between the sound generators and the audio pin.

## Interface
- CHANNELS, 4, number of voices (2..8)
- WIDTH, 12, sample width in bits, two's complement (8..16)
- ORDER, 1, modulator order (1 or 2; other values illegal)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sample_in  in  CHANNELS*WIDTH  voice samples, channel k at bits [k*WIDTH +: WIDTH], signed
- gain  in  CHANNELS*2  per-channel arithmetic right shift 0..3, channel k at [2k +: 2]
- mute  in  CHANNELS  per-channel mute, 1 = contributes 0
- update  in  1  single-cycle strobe, start a mix pass
- busy  out  1  mix pass in progress
- mix_out  out  WIDTH  last saturated mix, signed
- mix_valid  out  1  one-cycle pulse when mix_out changes
- clip  out  1  saturation occurred in last pass, valid with mix_valid, held until next pass
- pdm  out  1  registered PDM bit

## Operation
- States: IDLE, ACCUM.
- IDLE with update=1: snapshot sample_in, gain and mute into registers; clear accumulator; channel index = 0; go to ACCUM; busy=1.
- ACCUM, each cycle: acc += mute[i] ? 0 : (snap[i] >>> gain[i]). The shift is arithmetic (floor toward −inf). Then i++.
- Accumulator width is WIDTH+3 signed, which is overflow-free for CHANNELS ≤ 8.
- After channel CHANNELS−1 is added, the next cycle does the following, then returns to IDLE with busy=0:
  - saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1] and write mix_out;
  - set clip = 1 if clamped, else 0;
  - pulse mix_valid.
- update while busy=1 is ignored and not queued. Input changes after the snapshot do not affect the pass.
- Modulator runs every cycle on the held mix_out. Unsigned level u = mix_out with MSB inverted, range 0..2^WIDTH−1.
- ORDER=1: WIDTH-bit accumulator a. {c, a} <= a + u, with carry c. pdm <= c.
- ORDER=2: signed integrators i1 (WIDTH+2 bits) and i2 (WIDTH+4 bits). fb = pdm ? 2^WIDTH : 0.
  - i1 <= i1 + u − fb.
  - i2 <= i2 + i1 + u − 2·fb.
  - pdm <= (next i2 ≥ 0).
  - i1 and i2 saturate at their range limits, never wrap.
- Output density over any 2^WIDTH-cycle window:
  - ORDER=1: exactly u ones.
  - ORDER=2: within ±2 of u.

## Timing
- Reset values: busy 0, mix_valid 0, mix_out 0, clip 0, pdm 0, state IDLE.
- Reset also clears the modulator state: a, i1 and i2 = 0.
- update sampled high at edge t gives:
  - busy high from t+1;
  - adds at edges t+1..t+CHANNELS;
  - mix_out/clip/mix_valid updated at edge t+CHANNELS+1, which is also when busy falls.
- Earliest accepted re-trigger: update at edge t+CHANNELS+1, which is the same edge busy falls. A strobe there is accepted and starts a new pass.
- Modulator sees the new mix_out from edge t+CHANNELS+2. pdm has one cycle of register latency.
- rst asserted mid-pass: the pass is aborted and outputs return to reset values immediately. After release, IDLE waits for a fresh update.
- mix_valid and update are independent. If update arrives on the mix_valid cycle, mix_valid still pulses once.

## Test plan
All scenarios use CHANNELS=4, WIDTH=12.
- All channels 100, gain 0, no mute; update at t → busy rises at t+1, mix_out=400, clip=0, mix_valid pulse at t+5.
- All channels 2000 → mix_out=2047, clip=1. All channels −2048 → mix_out=−2048, clip=1. Next pass with all 0 → mix_out=0, clip=0.
- Exercise gain and mute with channels {1000,−5,700,300}, gains {2,1,0,0}, mute={0,0,1,0}: terms are 250, −3 (floor), 0 (muted) and 300, so mix_out=547. Change sample_in at t+1 → result unchanged.
- Re-trigger rules:
  - update pulsed at t and again at t+2 → exactly one mix_valid, at t+5, for the first snapshot;
  - update at t+5 → accepted, second mix_valid at t+10.
- ORDER=1 density:
  - mix_out=0 (u=2048) → pdm alternates 0,1 with exactly 2048 ones per 4096 cycles;
  - mix_out=2047 → 4095 ones per 4096;
  - mix_out=−2048 → pdm constant 0.
- ORDER=2 density with mix_out=−1024 (u=1024) → 1022..1026 ones per 4096-cycle window after 64 cycles of settling. Assert rst mid-pass at t+2 → busy, pdm, mix_out read 0 while rst is high with no mix_valid; the first pass after release behaves as in the first scenario.
